// File: rtl/propose_pkg.sv
// Shared definitions for the proposal control FSM: state encoding, default
// stage constants and the state-to-stage-enable decode.
package propose_pkg;

   localparam int DEFAULT_IDX_W         = 2;
   localparam int DEFAULT_STAGE_TIMEOUT = 16;
   localparam int DEFAULT_RANDOM_CYCLES = 2;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_BOOL    = 4'd1,
      ST_REDUCE  = 4'd2,
      ST_SELECT  = 4'd3,
      ST_DSIZES  = 4'd4,
      ST_RANDOM  = 4'd5,
      ST_DVALUES = 4'd6,
      ST_SAMPLE  = 4'd7,
      ST_DONE    = 4'd8
   } state_e;

   typedef struct packed {
      logic boolean_propose;
      logic reduce;
      logic select_segment;
      logic dsizes;
      logic random;
      logic dvalues;
      logic sampler;
   } stage_en_t;

   // Each working state owns exactly one datapath enable; IDLE and DONE own none.
   function automatic stage_en_t decode_enables(state_e s);
      stage_en_t en;
      en = '0;
      case (s)
         ST_BOOL:    en.boolean_propose = 1'b1;
         ST_REDUCE:  en.reduce          = 1'b1;
         ST_SELECT:  en.select_segment  = 1'b1;
         ST_DSIZES:  en.dsizes          = 1'b1;
         ST_RANDOM:  en.random          = 1'b1;
         ST_DVALUES: en.dvalues         = 1'b1;
         ST_SAMPLE:  en.sampler         = 1'b1;
         default:    en = '0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/propose_control_unit_if.sv
// Request/handshake and stage-enable bundle between the proposal sequencer
// and whoever drives it; slave is the sequencer side.
interface propose_control_unit_if #(
   parameter int IDX_W = propose_pkg::DEFAULT_IDX_W
) ();

   logic             in_start;
   logic             in_abort;
   logic             in_variable_is_integer;
   logic [IDX_W-1:0] in_variable_index;
   logic             in_reduce_done;
   logic             in_sample_valid;

   logic             out_boolean_propose_enable;
   logic             out_reduce_enable;
   logic             out_select_segment_enable;
   logic             out_DiscreteVariablesSizes_enable;
   logic             out_random_enable;
   logic             out_DiscreteValuesTable_enable;
   logic             out_sampler_enable;
   logic [IDX_W-1:0] out_variable_index;
   logic             out_busy;
   logic             out_done;
   logic             out_timeout;

   modport master (
      output in_start, in_abort, in_variable_is_integer, in_variable_index,
             in_reduce_done, in_sample_valid,
      input  out_boolean_propose_enable, out_reduce_enable, out_select_segment_enable,
             out_DiscreteVariablesSizes_enable, out_random_enable,
             out_DiscreteValuesTable_enable, out_sampler_enable,
             out_variable_index, out_busy, out_done, out_timeout
   );

   modport slave (
      input  in_start, in_abort, in_variable_is_integer, in_variable_index,
             in_reduce_done, in_sample_valid,
      output out_boolean_propose_enable, out_reduce_enable, out_select_segment_enable,
             out_DiscreteVariablesSizes_enable, out_random_enable,
             out_DiscreteValuesTable_enable, out_sampler_enable,
             out_variable_index, out_busy, out_done, out_timeout
   );

endinterface

// File: rtl/stage_timer.sv
// Saturating cycle counter for the handshake stages; expired flags the last
// cycle a stage may wait before the sequencer gives up.
module stage_timer import propose_pkg::*; #(
   parameter int STAGE_TIMEOUT = DEFAULT_STAGE_TIMEOUT
) (
   input  logic in_clock,
   input  logic in_reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = (STAGE_TIMEOUT > 1) ? $clog2(STAGE_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(STAGE_TIMEOUT - 1);

   logic [TW-1:0] count_q, count_d;

   // Holds at LAST rather than wrapping, so a late handshake never restarts the wait.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/propose_control_unit.sv
// Moore sequencer that walks one boolean or integer proposal through the
// datapath stages, with abort and per-stage handshake timeout.
module propose_control_unit import propose_pkg::*; #(
   parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX = DEFAULT_IDX_W,
   parameter int STAGE_TIMEOUT                    = DEFAULT_STAGE_TIMEOUT,
   parameter int RANDOM_CYCLES                    = DEFAULT_RANDOM_CYCLES
) (
   input  logic                  in_clock,
   input  logic                  in_reset,
   propose_control_unit_if.slave bus
);

   localparam int IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
   localparam int RW = (RANDOM_CYCLES > 1) ? $clog2(RANDOM_CYCLES) : 1;
   localparam logic [RW-1:0] RND_LAST = RW'(RANDOM_CYCLES - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            timeout_q, timeout_d;
   logic [RW-1:0]   rnd_cnt_q, rnd_cnt_d;
   logic            timer_en;
   logic            timer_expired;
   stage_en_t       stage_en;

   // The timer only runs while waiting on a handshake; any other state clears it.
   assign timer_en = (state_q == ST_REDUCE) || (state_q == ST_SAMPLE);

   stage_timer #(
      .STAGE_TIMEOUT(STAGE_TIMEOUT)
   ) u_stage_timer (
      .in_clock (in_clock),
      .in_reset (in_reset),
      .clear    (!timer_en),
      .enable   (timer_en),
      .expired  (timer_expired)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timeout_d = 1'b0;
      rnd_cnt_d = '0;
      if ((state_q != ST_IDLE) && bus.in_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_start) begin
                  idx_d   = bus.in_variable_index;
                  state_d = bus.in_variable_is_integer ? ST_REDUCE : ST_BOOL;
               end
            end
            ST_BOOL:    state_d = ST_DONE;
            // A handshake on the expiry cycle still counts as success.
            ST_REDUCE: begin
               if (bus.in_reduce_done) begin
                  state_d = ST_SELECT;
               end else if (timer_expired) begin
                  state_d   = ST_IDLE;
                  timeout_d = 1'b1;
               end
            end
            ST_SELECT:  state_d = ST_DSIZES;
            ST_DSIZES:  state_d = ST_RANDOM;
            ST_RANDOM: begin
               if (rnd_cnt_q == RND_LAST) begin
                  state_d = ST_DVALUES;
               end else begin
                  rnd_cnt_d = rnd_cnt_q + 1'b1;
               end
            end
            ST_DVALUES: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
               if (bus.in_sample_valid) begin
                  state_d = ST_DONE;
               end else if (timer_expired) begin
                  state_d   = ST_IDLE;
                  timeout_d = 1'b1;
               end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         timeout_q <= 1'b0;
         rnd_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
         rnd_cnt_q <= rnd_cnt_d;
      end
   end

   // Every output is a decode of registered state; timeout_q is the registered pulse.
   assign stage_en = decode_enables(state_q);

   assign bus.out_boolean_propose_enable        = stage_en.boolean_propose;
   assign bus.out_reduce_enable                 = stage_en.reduce;
   assign bus.out_select_segment_enable         = stage_en.select_segment;
   assign bus.out_DiscreteVariablesSizes_enable = stage_en.dsizes;
   assign bus.out_random_enable                 = stage_en.random;
   assign bus.out_DiscreteValuesTable_enable    = stage_en.dvalues;
   assign bus.out_sampler_enable                = stage_en.sampler;
   assign bus.out_variable_index                = idx_q;
   assign bus.out_busy                          = (state_q != ST_IDLE);
   assign bus.out_done                          = (state_q == ST_DONE);
   assign bus.out_timeout                       = timeout_q;

endmodule

// File: tb/tb_propose_control_unit.sv
// Bench for propose_control_unit: directed scenarios and random proposals,
// each compared cycle by cycle with a phase-list reference model.
module tb_propose_control_unit;

   localparam int IW = 2;
   localparam int TO = 16;
   localparam int RC = 2;

   typedef struct packed {
      logic          rst_n;
      logic          start;
      logic          abort;
      logic          is_int;
      logic [IW-1:0] idx;
      logic          reduce_done;
      logic          sample_valid;
   } in_t;

   typedef struct packed {
      logic [6:0]    en;
      logic          busy;
      logic          done;
      logic          timeout;
      logic [IW-1:0] idx;
   } out_t;

   logic          clk = 1'b0;
   logic          rst_n;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [IW-1:0] model_idx = '0;
   in_t           in_q[$];
   out_t          exp_q[$];

   propose_control_unit_if #(.IDX_W(IW)) bus ();

   propose_control_unit #(
      .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(IW),
      .STAGE_TIMEOUT(TO),
      .RANDOM_CYCLES(RC)
   ) dut (
      .in_clock (clk),
      .in_reset (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Enable bit order: 6 bool, 5 reduce, 4 select, 3 dsizes, 2 random, 1 dvalues, 0 sampler.
   function automatic out_t observe();
      out_t v;
      v.en = {bus.out_boolean_propose_enable, bus.out_reduce_enable,
              bus.out_select_segment_enable, bus.out_DiscreteVariablesSizes_enable,
              bus.out_random_enable, bus.out_DiscreteValuesTable_enable,
              bus.out_sampler_enable};
      v.busy    = bus.out_busy;
      v.done    = bus.out_done;
      v.timeout = bus.out_timeout;
      v.idx     = bus.out_variable_index;
      return v;
   endfunction

   function automatic in_t busy_noise();
      in_t v;
      v.rst_n        = 1'b1;
      v.start        = 1'($urandom_range(0, 1));
      v.abort        = 1'b0;
      v.is_int       = 1'($urandom_range(0, 1));
      v.idx          = IW'($urandom_range(0, 3));
      v.reduce_done  = 1'($urandom_range(0, 1));
      v.sample_valid = 1'($urandom_range(0, 1));
      return v;
   endfunction

   function automatic out_t busy_out(int bitpos, logic [IW-1:0] idx);
      out_t v;
      v.en      = (bitpos >= 0) ? 7'(1 << bitpos) : 7'd0;
      v.busy    = 1'b1;
      v.done    = (bitpos < 0);
      v.timeout = 1'b0;
      v.idx     = idx;
      return v;
   endfunction

   task automatic drive(input in_t v);
      rst_n                      = v.rst_n;
      bus.in_start               = v.start;
      bus.in_abort               = v.abort;
      bus.in_variable_is_integer = v.is_int;
      bus.in_variable_index      = v.idx;
      bus.in_reduce_done         = v.reduce_done;
      bus.in_sample_valid        = v.sample_valid;
   endtask

   task automatic check_out(input out_t exp, input string tag);
      out_t obs;
      obs = observe();
      checks++;
      assert (obs.en === exp.en) else begin
         errors++;
         $error("FAIL %s cyc=%0d enables observed=%b expected=%b", tag, cyc, obs.en, exp.en);
      end
      checks++;
      assert ({obs.busy, obs.done, obs.timeout} === {exp.busy, exp.done, exp.timeout}) else begin
         errors++;
         $error("FAIL %s cyc=%0d busy/done/timeout observed=%b expected=%b", tag, cyc,
                {obs.busy, obs.done, obs.timeout}, {exp.busy, exp.done, exp.timeout});
      end
      checks++;
      assert (obs.idx === exp.idx) else begin
         errors++;
         $error("FAIL %s cyc=%0d variable_index observed=%0d expected=%0d", tag, cyc, obs.idx, exp.idx);
      end
   endtask

   // Delays rd/sv count waiting cycles before the handshake; >= TO means it never comes.
   // abort_at/reset_at are cycle numbers after the start cycle (-1 = none).
   task automatic build_txn(input bit is_int, input logic [IW-1:0] idx, input int rd,
                            input int sv, input int abort_at, input int reset_at);
      int   ph_bit[7];
      int   ph_len[7];
      int   ph_hs[7];
      bit   ph_ok[7];
      int   nph;
      int   k;
      bit   stop;
      bit   tmo;
      in_t  vi;
      out_t vo;
      for (int p = 0; p < 7; p++) begin
         ph_hs[p] = 0;
         ph_ok[p] = 1'b1;
         ph_len[p] = 1;
      end
      vi = busy_noise();
      vi.start = 1'b1;
      vi.is_int = is_int;
      vi.idx = idx;
      vo = '0;
      vo.idx = model_idx;
      in_q.push_back(vi);
      exp_q.push_back(vo);
      model_idx = idx;
      if (!is_int) begin
         ph_bit[0] = 6;
         ph_bit[1] = -1;
         nph = 2;
      end else begin
         ph_bit[0] = 5; ph_hs[0] = 1; ph_ok[0] = (rd < TO); ph_len[0] = (rd < TO) ? rd + 1 : TO;
         ph_bit[1] = 4;
         ph_bit[2] = 3;
         ph_bit[3] = 2; ph_len[3] = RC;
         ph_bit[4] = 1;
         ph_bit[5] = 0; ph_hs[5] = 2; ph_ok[5] = (sv < TO); ph_len[5] = (sv < TO) ? sv + 1 : TO;
         ph_bit[6] = -1;
         nph = 7;
      end
      k = 0;
      stop = 1'b0;
      tmo = 1'b0;
      for (int p = 0; p < nph && !stop; p++) begin
         for (int j = 0; j < ph_len[p] && !stop; j++) begin
            k++;
            vi = busy_noise();
            if (ph_hs[p] == 1) vi.reduce_done = ph_ok[p] && (j == ph_len[p] - 1);
            if (ph_hs[p] == 2) vi.sample_valid = ph_ok[p] && (j == ph_len[p] - 1);
            vo = busy_out(ph_bit[p], idx);
            if (k == abort_at) begin
               vi.abort = 1'b1;
               stop = 1'b1;
            end else if (k == reset_at) begin
               vi.rst_n = 1'b0;
               stop = 1'b1;
               model_idx = '0;
            end else if ((ph_hs[p] != 0) && !ph_ok[p] && (j == ph_len[p] - 1)) begin
               tmo = 1'b1;
               stop = 1'b1;
            end
            in_q.push_back(vi);
            exp_q.push_back(vo);
         end
      end
      for (int t = 0; t < 2; t++) begin
         vi = busy_noise();
         vi.start = 1'b0;
         vi.abort = 1'($urandom_range(0, 1));
         vo = '0;
         vo.timeout = (t == 0) ? tmo : 1'b0;
         vo.idx = model_idx;
         in_q.push_back(vi);
         exp_q.push_back(vo);
      end
   endtask

   task automatic run_queue(input string tag);
      in_t  vi;
      out_t vo;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         vo = exp_q.pop_front();
         vi = in_q.pop_front();
         check_out(vo, tag);
         drive(vi);
         cyc++;
      end
   endtask

   initial begin
      in_t  vi;
      out_t zero;
      vi = '0;
      zero = '0;
      drive(vi);
      @(negedge clk);
      check_out(zero, "reset_a");
      @(negedge clk);
      check_out(zero, "reset_b");
      vi.rst_n = 1'b1;
      drive(vi);

      build_txn(1'b0, 2'd2, 0, 0, -1, -1);
      run_queue("bool_idx2");
      build_txn(1'b1, 2'd1, 3, 2, -1, -1);
      run_queue("int_basic");
      build_txn(1'b1, 2'd3, 16, 0, -1, -1);
      run_queue("reduce_timeout");
      build_txn(1'b1, 2'd2, 0, 0, 4, -1);
      run_queue("abort_random");
      build_txn(1'b1, 2'd3, 0, 10, -1, 9);
      run_queue("reset_in_sample");
      build_txn(1'b1, 2'd1, 15, 15, -1, -1);
      run_queue("handshake_on_expiry");
      build_txn(1'b1, 2'd0, 1, 16, -1, -1);
      run_queue("sample_timeout");
      build_txn(1'b0, 2'd3, 0, 0, 1, -1);
      run_queue("abort_bool");

      for (int t = 0; t < 40; t++) begin
         bit ii;
         int ab;
         int rs;
         ii = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
         rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : -1;
         build_txn(ii, IW'($urandom_range(0, 3)), int'($urandom_range(0, 17)),
                   int'($urandom_range(0, 17)), ab, rs);
         run_queue("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/propose_control_unit.md
PROPOSE_CONTROL_UNIT -- requirements
Module: propose_control_unit

Interface
REQ-001 Parameter MAX_BIT_WIDTH_OF_VARIABLES_INDEX, default 2, width of the variable index.
REQ-002 Parameter STAGE_TIMEOUT, default 16, maximum cycles to wait in any handshake stage.
REQ-003 Parameter RANDOM_CYCLES, default 2, cycles to hold out_random_enable.
REQ-004 in_clock  in  1  the single clock; all state changes on its rising edge.
REQ-005 in_reset  in  1  reset, synchronous and active-low.
REQ-006 in_start  in  1  request one proposal; sampled only in IDLE.
REQ-007 in_abort  in  1  abandon the current proposal.
REQ-008 in_variable_is_integer  in  1  0 = boolean move, 1 = integer move.
REQ-009 in_variable_index  in  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  variable to change.
REQ-010 in_reduce_done  in  1  reduce stage finished.
REQ-011 in_sample_valid  in  1  sampler output valid.
REQ-012 out_boolean_propose_enable, out_reduce_enable, out_select_segment_enable, out_DiscreteVariablesSizes_enable, out_random_enable, out_DiscreteValuesTable_enable, out_sampler_enable  out  1 each  datapath stage enables.
REQ-013 out_variable_index  out  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  index latched at start.
REQ-014 out_busy  out  1  high in every state except IDLE.
REQ-015 out_done  out  1  one-cycle pulse, proposal complete.
REQ-016 out_timeout  out  1  one-cycle pulse, stage timed out.

Function
REQ-017 The FSM SHALL be Moore: all outputs decode from registered state only; at most one stage enable is high in any cycle.
REQ-018 States SHALL be IDLE, BOOL, REDUCE, SELECT, DSIZES, RANDOM, DVALUES, SAMPLE, DONE.
REQ-019 IDLE + in_start SHALL latch index/type; type 0 -> BOOL, type 1 -> REDUCE.
REQ-020 BOOL SHALL last 1 cycle -> DONE; boolean start-to-out_done latency is 2 cycles.
REQ-021 REDUCE SHALL hold out_reduce_enable until in_reduce_done is sampled high -> SELECT.
REQ-022 SELECT and DSIZES SHALL each last 1 cycle, in that order -> RANDOM.
REQ-023 RANDOM SHALL last exactly RANDOM_CYCLES cycles -> DVALUES (1 cycle) -> SAMPLE.
REQ-024 SAMPLE SHALL hold out_sampler_enable until in_sample_valid is sampled high -> DONE.
REQ-025 DONE SHALL last 1 cycle asserting out_done -> IDLE; in_start is ignored in DONE.
REQ-026 Stage timer SHALL clear on entry to REDUCE/SAMPLE; if it reaches STAGE_TIMEOUT-1 with no handshake -> out_timeout next cycle, IDLE, no out_done.
REQ-027 Handshake arriving on the timeout cycle SHALL win (normal transition, no timeout).
REQ-028 in_abort in any non-IDLE state SHALL force IDLE next cycle, no done/timeout; abort beats handshake and timeout.
REQ-029 in_start while busy SHALL be ignored and not queued.
REQ-030 out_variable_index SHALL hold its latched value until the next accepted start.
REQ-031 Timer width SHALL be $clog2(STAGE_TIMEOUT) and SHALL not wrap.

Reset
REQ-032 in_reset low at a rising edge SHALL force IDLE, timer 0, out_variable_index 0, all outputs 0, overriding every other input, including mid-proposal.

Structure
REQ-033 State encoding and the default timeout/random-cycle constants SHALL live in shared package propose_pkg.
REQ-034 Timer SHALL be sub-module stage_timer (clear, enable, expired).

Verification
REQ-035 Boolean: start, type 0, index 2 -> BOOL 1 cycle, out_done at cycle 2, out_variable_index=2.
REQ-036 Integer: start, type 1, reduce_done after 3 cycles, sample_valid after 2 -> exact enable order, RANDOM high 2 cycles, single out_done.
REQ-037 Timeout: type 1, in_reduce_done held low -> out_timeout after 16 REDUCE cycles, IDLE, no done.
REQ-038 Abort in RANDOM, plus in_start during busy -> IDLE next cycle, start ignored, no done.
REQ-039 Reset low in SAMPLE -> all outputs 0 next edge; in_reduce_done on timeout cycle -> SELECT, no timeout.
